// File: rtl/uart_tx_drain.sv
// Drains bytes from a FIFO and transmits each as an 8N1 UART frame,
// optionally upper-casing ASCII letters on the way out.

module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CAPITALIZE   = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic       o_rd_en,
   input  logic [7:0] i_rd_data,
   input  logic       i_rd_valid,
   input  logic       i_empty,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_tx_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   state_t            state_r;
   logic [BAUD_W-1:0] baud_r;
   logic [2:0]        bit_idx_r;
   logic [7:0]        shift_r;
   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic              baud_end_s;
   logic              rd_en_s;
   logic              idle_s;
   logic              wait_s;

   function automatic logic [7:0] cap_map(input logic [7:0] b);
      logic [7:0] r;
      if ((CAPITALIZE != 0) && (b >= 8'h61) && (b <= 8'h7A)) begin
         r = b - 8'h20;
      end else begin
         r = b;
      end
      return r;
   endfunction

   assign baud_end_s = (baud_r == BAUD_LAST);
   assign idle_s     = (state_r == ST_IDLE);
   assign wait_s     = (state_r == ST_WAIT);

   // Read request is combinational from the registered state so the FIFO
   // answers during WAIT; gated by reset so nothing is requested while held.
   always_comb begin
      rd_en_s = 1'b0;
      if (idle_s && !i_empty && !i_rst) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Frame sequencer: state, baud/bit counters, shift register and line driver.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r   <= ST_IDLE;
         baud_r    <= '0;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               baud_r    <= '0;
               bit_idx_r <= 3'd0;
               tx_r      <= 1'b1;
               if (!i_empty) begin
                  state_r <= ST_WAIT;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_WAIT: begin
               baud_r    <= '0;
               bit_idx_r <= 3'd0;
               if (i_rd_valid) begin
                  shift_r <= cap_map(i_rd_data);
                  state_r <= ST_START;
                  tx_r    <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  // No data arrived: give up quietly and re-arbitrate from IDLE.
                  state_r <= ST_IDLE;
                  tx_r    <= 1'b1;
                  busy_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_end_s) begin
                  baud_r    <= '0;
                  bit_idx_r <= 3'd0;
                  state_r   <= ST_DATA;
                  tx_r      <= shift_r[0];
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            ST_DATA: begin
               if (baud_end_s) begin
                  baud_r <= '0;
                  if (bit_idx_r == 3'd7) begin
                     bit_idx_r <= 3'd0;
                     state_r   <= ST_STOP;
                     tx_r      <= 1'b1;
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                     shift_r   <= {1'b0, shift_r[7:1]};
                     tx_r      <= shift_r[1];
                  end
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            ST_STOP: begin
               if (baud_end_s) begin
                  baud_r  <= '0;
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  baud_r <= baud_r + BAUD_ONE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               baud_r    <= '0;
               bit_idx_r <= 3'd0;
               tx_r      <= 1'b1;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign o_rd_en   = rd_en_s;
   assign o_tx      = tx_r;
   assign o_busy    = busy_r;
   assign o_tx_done = done_r;

   uart_tx_drain_chk #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .BAUD_W       (BAUD_W)
   ) u_chk (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .idle_s    (idle_s),
      .wait_s    (wait_s),
      .rd_en_s   (rd_en_s),
      .tx_s      (tx_r),
      .busy_s    (busy_r),
      .done_s    (done_r),
      .baud_s    (baud_r)
   );

endmodule

// Protocol invariants of uart_tx_drain; holds no design state.
module uart_tx_drain_chk #(
   parameter int CLKS_PER_BIT = 16,
   parameter int BAUD_W       = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   input logic              idle_s,
   input logic              wait_s,
   input logic              rd_en_s,
   input logic              tx_s,
   input logic              busy_s,
   input logic              done_s,
   input logic [BAUD_W-1:0] baud_s
);

   a_rd_en_only_idle: assert property (@(posedge i_clk) disable iff (i_rst)
      rd_en_s |-> idle_s);

   a_busy_matches_state: assert property (@(posedge i_clk) disable iff (i_rst)
      busy_s == !idle_s);

   a_line_high_between_frames: assert property (@(posedge i_clk) disable iff (i_rst)
      (idle_s || wait_s) |-> tx_s);

   a_done_single_cycle: assert property (@(posedge i_clk) disable iff (i_rst)
      done_s |=> !done_s);

   a_done_in_idle: assert property (@(posedge i_clk) disable iff (i_rst)
      done_s |-> idle_s);

   a_baud_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
      int'(baud_s) < CLKS_PER_BIT);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed/randomized bench for uart_tx_drain at CLKS_PER_BIT=4 with a queue-free
// array FIFO model and a frame-level reference built from the 8N1 rules.

module tb_uart_tx_drain;

   localparam int CPB = 4;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       rd_en;
   logic [7:0] rd_data = 8'h00;
   logic       rd_valid = 1'b0;
   logic       empty;
   logic       tx;
   logic       busy;
   logic       tx_done;

   logic       nc_empty;
   logic       nc_rd_en;
   logic       nc_valid = 1'b0;
   logic [7:0] nc_data = 8'h7A;
   logic       nc_tx;
   logic       nc_busy;
   logic       nc_done;

   logic [7:0] mem [0:255];
   int         wr_ptr;
   int         rd_ptr = 0;
   bit         withhold;
   bit         spurious;

   int         pass_cnt = 0;
   int         fail_cnt = 0;
   int         total_cnt = 0;
   int         rd_cnt = 0;
   int         done_cnt = 0;

   logic [7:0] batch [0:15];
   int         batch_n;

   always #5 i_clk = ~i_clk;

   uart_tx_drain #(.CLKS_PER_BIT(CPB), .CAPITALIZE(1)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_rd_en    (rd_en),
      .i_rd_data  (rd_data),
      .i_rd_valid (rd_valid),
      .i_empty    (empty),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_tx_done  (tx_done)
   );

   uart_tx_drain #(.CLKS_PER_BIT(CPB), .CAPITALIZE(0)) dut_nc (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_rd_en    (nc_rd_en),
      .i_rd_data  (nc_data),
      .i_rd_valid (nc_valid),
      .i_empty    (nc_empty),
      .o_tx       (nc_tx),
      .o_busy     (nc_busy),
      .o_tx_done  (nc_done)
   );

   assign empty = (rd_ptr == wr_ptr);

   // FIFO model: data appears the cycle after an accepted read; optional junk strobes.
   always @(posedge i_clk) begin
      if (rd_en && !withhold) begin
         rd_valid <= 1'b1;
         rd_data  <= mem[rd_ptr[7:0]];
         rd_ptr   <= rd_ptr + 1;
      end else begin
         rd_valid <= spurious ? 1'($urandom_range(0, 1)) : 1'b0;
         rd_data  <= 8'($urandom);
      end
   end

   always @(posedge i_clk) begin
      nc_valid <= nc_rd_en;
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge i_clk) begin
      if (rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] ref_cap(input logic [7:0] b, input bit cap);
      // Lower-case ASCII letters become upper case by dropping 0x20.
      if (cap && b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
      return b;
   endfunction

   function automatic logic [63:0] ref_frame(input logic [7:0] b);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 10 * CPB; i++) begin
         int bit_no;
         bit_no = i / CPB;
         if (bit_no == 0)      f[i] = 1'b0;
         else if (bit_no == 9) f[i] = 1'b1;
         else                  f[i] = b[bit_no - 1];
      end
      return f;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   // Waits for a start bit, returns the 40 line samples of the frame and the
   // number of high cycles seen before it began.
   task automatic capture(input bit use_nc, output logic [63:0] bits, output int gap);
      logic t;
      bits = '0;
      gap  = 0;
      t    = 1'b1;
      for (int n = 0; n < 400; n++) begin
         @(negedge i_clk);
         t = use_nc ? nc_tx : tx;
         if (t == 1'b0) break;
         gap++;
      end
      check("start_seen", 64'(t), 64'd0);
      bits[0] = t;
      for (int i = 1; i < 10 * CPB; i++) begin
         @(negedge i_clk);
         bits[i] = use_nc ? nc_tx : tx;
      end
   endtask

   task automatic run_batch(input string tag);
      logic [63:0] fr;
      int gap;
      int r0;
      int d0;
      logic acc;
      @(posedge i_clk); #1;
      r0 = rd_cnt;
      d0 = done_cnt;
      for (int k = 0; k < batch_n; k++) push(batch[k]);
      for (int k = 0; k < batch_n; k++) begin
         capture(1'b0, fr, gap);
         check($sformatf("%s_frame%0d", tag, k), fr, ref_frame(ref_cap(batch[k], 1'b1)));
         if (k > 0) check($sformatf("%s_gap%0d", tag, k), 64'(gap), 64'd2);
      end
      repeat (3) @(negedge i_clk);
      #1;
      check({tag, "_rd_pulses"}, 64'(rd_cnt - r0), 64'(batch_n));
      check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(batch_n));
      acc = 1'b0;
      repeat (20) begin
         @(negedge i_clk);
         acc = acc | busy | rd_en | ~tx;
      end
      check({tag, "_idle_after"}, 64'(acc), 64'd0);
   endtask

   initial begin
      logic [63:0] fr;
      int gap;
      int r0;
      int d0;
      logic [2:0] acc3;
      logic [7:0] b0;
      logic [7:0] b1;

      i_rst    = 1'b1;
      wr_ptr   = 0;
      withhold = 1'b0;
      spurious = 1'b0;
      nc_empty = 1'b1;

      // Reset state, with a byte already waiting in the FIFO.
      push(8'h61);
      repeat (3) @(negedge i_clk);
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      check("rst_done", 64'(tx_done), 64'd0);

      // Single lowercase 'a' goes out as 'A'.
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      r0 = rd_cnt;
      d0 = done_cnt;
      capture(1'b0, fr, gap);
      check("frame_61", fr, ref_frame(8'h41));
      @(negedge i_clk);
      check("done_pulse", 64'(tx_done), 64'd1);
      check("tx_high_after_stop", 64'(tx), 64'd1);
      @(negedge i_clk);
      check("done_single", 64'(tx_done), 64'd0);
      repeat (5) @(negedge i_clk);
      #1;
      check("one_rd_pulse", 64'(rd_cnt - r0), 64'd1);
      check("one_done_pulse", 64'(done_cnt - d0), 64'd1);
      check("busy_low", 64'(busy), 64'd0);

      // Capitalize boundaries, with junk read strobes outside WAIT.
      spurious = 1'b1;
      batch[0] = 8'h60; batch[1] = 8'h7A; batch[2] = 8'h7B; batch[3] = 8'h41;
      batch[4] = 8'h61;
      for (int k = 5; k < 9; k++) batch[k] = 8'($urandom_range(32'h5C, 32'h7F));
      batch_n = 9;
      run_batch("bound");

      // Three-byte preload, fully random values.
      for (int k = 0; k < 3; k++) batch[k] = 8'($urandom);
      batch_n = 3;
      run_batch("three");
      spurious = 1'b0;

      // Empty FIFO for 100 cycles.
      acc3 = 3'b000;
      repeat (100) begin
         @(negedge i_clk);
         acc3 = acc3 | {rd_en, ~tx, busy};
      end
      check("empty_100", 64'(acc3), 64'd0);

      // Reset during data bit 3 (bit 3 forced low so the line visibly rises).
      b0 = 8'($urandom) & 8'hF7;
      b1 = 8'($urandom);
      @(posedge i_clk); #1;
      push(b0);
      push(b1);
      fr = '0;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clk);
         if (tx == 1'b0) break;
      end
      repeat (4 * CPB + 1) @(negedge i_clk);
      check("bit3_low_before_rst", 64'(tx), 64'd0);
      #2;
      d0 = done_cnt;
      i_rst = 1'b1;
      #1;
      check("rst_async_tx", 64'(tx), 64'd1);
      check("rst_async_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      capture(1'b0, fr, gap);
      check("frame_after_rst", fr, ref_frame(ref_cap(b1, 1'b1)));
      repeat (2) @(negedge i_clk);
      #1;
      check("no_done_for_abandoned", 64'(done_cnt - d0), 64'd1);

      // Read data withheld: WAIT falls back to IDLE without a start bit.
      @(posedge i_clk); #1;
      withhold = 1'b1;
      b0 = 8'($urandom);
      push(b0);
      for (int n = 0; n < 20; n++) begin
         @(negedge i_clk);
         if (rd_en == 1'b1) break;
      end
      check("wh_rd_en", 64'(rd_en), 64'd1);
      @(negedge i_clk);
      check("wh_wait_state", {61'd0, busy, tx, rd_en}, 64'b110);
      @(negedge i_clk);
      check("wh_back_idle", {61'd0, busy, tx, rd_en}, 64'b011);
      acc3 = 3'b000;
      repeat (20) begin
         @(negedge i_clk);
         acc3[0] = acc3[0] | ~tx;
      end
      check("wh_no_start", 64'(acc3), 64'd0);
      @(posedge i_clk); #1;
      withhold = 1'b0;
      capture(1'b0, fr, gap);
      check("wh_frame", fr, ref_frame(ref_cap(b0, 1'b1)));

      // CAPITALIZE=0 instance passes 'z' through.
      @(posedge i_clk); #1;
      nc_empty = 1'b0;
      @(posedge i_clk); #1;
      nc_empty = 1'b1;
      capture(1'b1, fr, gap);
      check("nocap_frame_7a", fr, ref_frame(ref_cap(8'h7A, 1'b0)));
      repeat (4) @(negedge i_clk);
      check("nocap_idle", {62'd0, nc_busy, nc_tx}, 64'b01);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
